// File: rtl/alu_ex_pkg.sv
// Shared constants for the ALU execution unit: widths, op encodings, tags and FSM states.
// The M-extension encodings are only consumed when ALU_MULDIV_EN is defined.
package alu_ex_pkg;

  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned ROB_TAG_WIDTH       = 4;
  localparam int unsigned INSIDE_OPCODE_WIDTH = 6;

  localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;

  typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_op_e;

  localparam logic [INSIDE_OPCODE_WIDTH-1:0] NOP = OP_NOP;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } md_state_e;

  function automatic logic is_muldiv_op(input logic [INSIDE_OPCODE_WIDTH-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_ex_muldiv.sv
// Iterative radix-2 multiply/divide: 32 shift-add / shift-subtract steps on operand
// magnitudes, sign correction applied combinationally while in DONE.
module alu_muldiv
  import alu_ex_pkg::*;
(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_rdy,
  input  logic                           i_clear,
  input  logic                           i_start,
  input  logic [INSIDE_OPCODE_WIDTH-1:0] i_op,
  input  logic [DATA_WIDTH-1:0]          i_a,
  input  logic [DATA_WIDTH-1:0]          i_b,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [DATA_WIDTH-1:0]          o_result
);

  md_state_e r_state, w_state_nxt;

  logic [4:0]                     r_cnt;
  logic [63:0]                    r_acc;
  logic [31:0]                    r_b;
  logic                           r_is_mul;
  logic                           r_neg;
  logic                           r_rem_neg;
  logic [INSIDE_OPCODE_WIDTH-1:0] r_op;

  logic        w_signed_a, w_signed_b, w_is_mul, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_mul_sum, w_div_rem;
  logic [31:0] w_div_sub;
  logic        w_div_ge;
  logic [63:0] w_acc_step, w_prod;
  logic [31:0] w_quo, w_rem, w_result;

  assign w_signed_a = i_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign w_signed_b = i_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign w_is_mul   = i_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign w_a_neg    = w_signed_a & i_a[31];
  assign w_b_neg    = w_signed_b & i_b[31];
  assign w_a_mag    = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_b_mag    = w_b_neg ? (~i_b + 32'd1) : i_b;

  // Multiply: r_acc = {partial, multiplier}; divide: r_acc = {remainder, quotient}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_div_rem  = r_acc[63:31];
  assign w_div_ge   = w_div_rem >= {1'b0, r_b};
  assign w_div_sub  = w_div_rem[31:0] - r_b;
  assign w_acc_step = r_is_mul ? {w_mul_sum, r_acc[31:1]}
                               : {(w_div_ge ? w_div_sub : w_div_rem[31:0]), r_acc[30:0], w_div_ge};

  assign w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_rem_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_comb begin
    w_result = w_rem;
    case (r_op)
      OP_MUL:                        w_result = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_result = w_prod[63:32];
      OP_DIV, OP_DIVU:               w_result = w_quo;
      default:                       w_result = w_rem;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= MD_IDLE;
    end else if (i_rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_state_nxt = MD_CALC;
      MD_CALC: if (r_cnt == 5'd31) w_state_nxt = MD_DONE;
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (i_clear) w_state_nxt = MD_IDLE;
  end

  // Divide by zero leaves the quotient at all ones, so its sign fix is suppressed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_is_mul  <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_op      <= '0;
    end else if (i_rdy) begin
      if (r_state == MD_IDLE && i_start) begin
        r_cnt     <= '0;
        r_op      <= i_op;
        r_is_mul  <= w_is_mul;
        r_b       <= w_is_mul ? w_a_mag : w_b_mag;
        r_acc     <= {32'd0, (w_is_mul ? w_b_mag : w_a_mag)};
        r_neg     <= (w_a_neg ^ w_b_neg) & (w_is_mul | (i_b != '0));
        r_rem_neg <= w_a_neg;
      end else if (r_state == MD_CALC) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= w_acc_step;
      end
    end
  end

  assign o_busy   = (r_state != MD_IDLE);
  assign o_done   = (r_state == MD_DONE);
  assign o_result = w_result;

endmodule

// File: rtl/alu_ex.sv
// RV32I integer execution unit driving the ALU CDB and ROB branch outcome.
// Define ALU_MULDIV_EN to add the iterative M-extension path and the station stall.
module alu_ex
  import alu_ex_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           in_rob_clear,
  input  logic [INSIDE_OPCODE_WIDTH-1:0] in_rs_op,
  input  logic [DATA_WIDTH-1:0]          in_rs_value1,
  input  logic [DATA_WIDTH-1:0]          in_rs_value2,
  input  logic [DATA_WIDTH-1:0]          in_rs_imm,
  input  logic [DATA_WIDTH-1:0]          in_rs_pc,
  input  logic [ROB_TAG_WIDTH-1:0]       in_rs_rob_tag,
  output logic                           out_rs_stall,
  output logic [DATA_WIDTH-1:0]          out_cdb_value,
  output logic [ROB_TAG_WIDTH-1:0]       out_cdb_tag,
  output logic                           out_rob_jump,
  output logic [DATA_WIDTH-1:0]          out_rob_target
);

  logic [DATA_WIDTH-1:0]    r_cdb_value;
  logic [ROB_TAG_WIDTH-1:0] r_cdb_tag;
  logic                     r_rob_jump;
  logic [DATA_WIDTH-1:0]    r_rob_target;

  logic                     w_issue, w_accept, w_simple;
  logic [DATA_WIDTH-1:0]    w_value, w_target, w_pc4, w_pc_imm, w_jalr_sum;
  logic                     w_jump, w_br_take;
  logic [4:0]               w_shamt_r, w_shamt_i;
  logic                     w_md_done;
  logic [DATA_WIDTH-1:0]    w_md_result;
  logic [ROB_TAG_WIDTH-1:0] w_md_tag;

  assign w_issue    = rdy & ~in_rob_clear & (in_rs_op != NOP) & (in_rs_rob_tag != ZERO_TAG_ROB);
  assign w_pc4      = in_rs_pc + 32'd4;
  assign w_pc_imm   = in_rs_pc + in_rs_imm;
  assign w_jalr_sum = in_rs_value1 + in_rs_imm;
  assign w_shamt_r  = in_rs_value2[4:0];
  assign w_shamt_i  = in_rs_imm[4:0];

  always_comb begin
    w_br_take = 1'b0;
    case (in_rs_op)
      OP_BEQ:  w_br_take = (in_rs_value1 == in_rs_value2);
      OP_BNE:  w_br_take = (in_rs_value1 != in_rs_value2);
      OP_BLT:  w_br_take = ($signed(in_rs_value1) <  $signed(in_rs_value2));
      OP_BGE:  w_br_take = ($signed(in_rs_value1) >= $signed(in_rs_value2));
      OP_BLTU: w_br_take = (in_rs_value1 <  in_rs_value2);
      OP_BGEU: w_br_take = (in_rs_value1 >= in_rs_value2);
      default: w_br_take = 1'b0;
    endcase
  end

  always_comb begin
    w_value  = '0;
    w_jump   = 1'b0;
    w_target = '0;
    case (in_rs_op)
      OP_LUI:   w_value = in_rs_imm;
      OP_AUIPC: w_value = w_pc_imm;
      OP_JAL: begin
        w_value  = w_pc4;
        w_jump   = 1'b1;
        w_target = w_pc_imm;
      end
      OP_JALR: begin
        w_value  = w_pc4;
        w_jump   = 1'b1;
        w_target = {w_jalr_sum[31:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        w_jump   = w_br_take;
        w_target = w_br_take ? w_pc_imm : w_pc4;
      end
      OP_ADD:   w_value = in_rs_value1 + in_rs_value2;
      OP_SUB:   w_value = in_rs_value1 - in_rs_value2;
      OP_SLL:   w_value = in_rs_value1 << w_shamt_r;
      OP_SLT:   w_value = {31'd0, $signed(in_rs_value1) < $signed(in_rs_value2)};
      OP_SLTU:  w_value = {31'd0, in_rs_value1 < in_rs_value2};
      OP_XOR:   w_value = in_rs_value1 ^ in_rs_value2;
      OP_SRL:   w_value = in_rs_value1 >> w_shamt_r;
      OP_SRA:   w_value = $unsigned($signed(in_rs_value1) >>> w_shamt_r);
      OP_OR:    w_value = in_rs_value1 | in_rs_value2;
      OP_AND:   w_value = in_rs_value1 & in_rs_value2;
      OP_ADDI:  w_value = in_rs_value1 + in_rs_imm;
      OP_SLTI:  w_value = {31'd0, $signed(in_rs_value1) < $signed(in_rs_imm)};
      OP_SLTIU: w_value = {31'd0, in_rs_value1 < in_rs_imm};
      OP_XORI:  w_value = in_rs_value1 ^ in_rs_imm;
      OP_ORI:   w_value = in_rs_value1 | in_rs_imm;
      OP_ANDI:  w_value = in_rs_value1 & in_rs_imm;
      OP_SLLI:  w_value = in_rs_value1 << w_shamt_i;
      OP_SRLI:  w_value = in_rs_value1 >> w_shamt_i;
      OP_SRAI:  w_value = $unsigned($signed(in_rs_value1) >>> w_shamt_i);
      default:  w_value = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic                     w_is_md, w_md_busy, w_md_start;
  logic [ROB_TAG_WIDTH-1:0] r_md_tag;

  assign w_is_md      = is_muldiv_op(in_rs_op);
  assign w_accept     = w_issue & ~w_md_busy;
  assign w_simple     = w_accept & ~w_is_md;
  assign w_md_start   = w_accept & w_is_md;
  assign w_md_tag     = r_md_tag;
  assign out_rs_stall = w_md_busy;

  alu_muldiv u_muldiv (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_rdy    (rdy),
    .i_clear  (in_rob_clear),
    .i_start  (w_md_start),
    .i_op     (in_rs_op),
    .i_a      (in_rs_value1),
    .i_b      (in_rs_value2),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_md_tag <= ZERO_TAG_ROB;
    end else if (w_md_start) begin
      r_md_tag <= in_rs_rob_tag;
    end
  end

  a_no_issue_while_stalled: assert property (@(posedge clk) disable iff (rst) !(w_issue && w_md_busy))
    else $error("alu_ex: issue dropped while out_rs_stall is high");
`else
  assign w_accept     = w_issue;
  assign w_simple     = w_accept;
  assign w_md_done    = 1'b0;
  assign w_md_result  = '0;
  assign w_md_tag     = ZERO_TAG_ROB;
  assign out_rs_stall = 1'b0;
`endif

  // Clear outranks a finishing mul/div, which outranks a fresh simple issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_value  <= '0;
      r_cdb_tag    <= ZERO_TAG_ROB;
      r_rob_jump   <= 1'b0;
      r_rob_target <= '0;
    end else if (rdy) begin
      if (in_rob_clear) begin
        r_cdb_tag  <= ZERO_TAG_ROB;
        r_rob_jump <= 1'b0;
      end else if (w_md_done) begin
        r_cdb_tag    <= w_md_tag;
        r_cdb_value  <= w_md_result;
        r_rob_jump   <= 1'b0;
        r_rob_target <= '0;
      end else if (w_simple) begin
        r_cdb_tag    <= in_rs_rob_tag;
        r_cdb_value  <= w_value;
        r_rob_jump   <= w_jump;
        r_rob_target <= w_target;
      end else begin
        r_cdb_tag  <= ZERO_TAG_ROB;
        r_rob_jump <= 1'b0;
      end
    end
  end

  assign out_cdb_value  = r_cdb_value;
  assign out_cdb_tag    = r_cdb_tag;
  assign out_rob_jump   = r_rob_jump;
  assign out_rob_target = r_rob_target;

endmodule
